// File: rtl/lcg_stream_checker.sv
// lcg_stream_checker
// Receive-side checker for a 128-bit LCG random stream. Acquires the
// sequence from the incoming words, locks after LOCK_COUNT consecutive
// correct predictions, then flags, counts and tolerates mismatches. Lock is
// dropped after LOCK_COUNT consecutive mismatches.
//
// Optional feature macro: LCG_CHK_SEED_EN
//   defined   - adds a `seed` input. Reset and resync preload the prediction
//               with the seed and start directly in SYNC.
//   undefined - acquisition starts in IDLE from the first accepted word.
module lcg_stream_checker #(
  parameter int                 WIDTH      = 128,
  parameter logic [WIDTH-1:0]   MULTIPLIER = 128'hF0451B9CE7D248FA119D3C2B5AB76403,
  parameter logic [WIDTH-1:0]   INCREMENT  = 128'h9876DE42A3B150CFA2D9E7B43C1F88B0,
  parameter int                 LOCK_COUNT = 4,
  parameter int                 CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resync,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef LCG_CHK_SEED_EN
  input  logic [WIDTH-1:0] seed,
`endif
  output logic             in_ready,
  output logic             locked,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [WIDTH-1:0] expected
);

  // Match and miss runs both count up to LOCK_COUNT.
  localparam int               MC_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOCKED
  } state_e;

  // Where acquisition (re)starts after reset or resync.
`ifdef LCG_CHK_SEED_EN
  localparam state_e START_STATE = ST_SYNC;
  logic [WIDTH-1:0] start_pred;
  assign start_pred = seed;
`else
  localparam state_e START_STATE = ST_IDLE;
  logic [WIDTH-1:0] start_pred;
  assign start_pred = '0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [MC_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             accept;
  logic             hit;
  logic             lose_lock;
  logic [WIDTH-1:0] lcg_src;
  logic [WIDTH-1:0] lcg_next;

  assign in_ready = rst & ~resync;
  assign accept   = in_valid & in_ready;
  assign hit      = (in_data == pred_q);

  // The LOCK_COUNT-th consecutive miss while locked forces reacquisition.
  assign lose_lock = (state_q == ST_LOCKED) && accept && !hit &&
                     (miss_cnt_q == LOCK_LAST);

  // One shared multiplier: while locked the prediction free-runs from pred,
  // everywhere else it is seeded from the received word (in SYNC a hit means
  // in_data == pred, so either operand gives the same result).
  assign lcg_src  = ((state_q == ST_LOCKED) && !lose_lock) ? pred_q : in_data;
  assign lcg_next = lcg_src * MULTIPLIER + INCREMENT;

  // Next-state and counter logic for the acquisition/lock FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mismatch_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (resync) begin
      state_d     = START_STATE;
      pred_d      = start_pred;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + 1'b1;
      pred_d     = lcg_next;
      unique case (state_q)
        ST_IDLE: begin
          match_cnt_d = '0;
          state_d     = ST_SYNC;
        end
        ST_SYNC: begin
          if (hit) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            mismatch_d = 1'b1;
            err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
            miss_cnt_d = miss_cnt_q + 1'b1;
            if (lose_lock) begin
              state_d     = ST_SYNC;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= START_STATE;
      pred_q      <= start_pred;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign mismatch   = mismatch_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;
  assign expected   = pred_q;

endmodule
